mmu_bank_server: RTL and testbench
==================================

# mmu_bank_server

Memory responder on the far side of the SIMD lanes' MMU request ports. It accepts one read or write request per lane per instruction into a banked on-chip word store of 9-bit colour-index words. Requests that hit distinct banks are served in the same cycle. Bank conflicts are serialised by asserting `stall` back to the lanes until every lane in the set has been served. Read data returns on each lane's `mmu_read_data` one cycle after that lane's grant.

## Interface
- `NUM_LANES`, 4, number of SIMD lanes served
- `NUM_BANKS`, 4, power of two; bank = `addr[log2(NUM_BANKS)-1:0]`
- `BANK_DEPTH`, 4096, words per bank; row = next `log2(BANK_DEPTH)` address bits, upper bits ignored
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `lane_rd_en`  in  NUM_LANES  lane issues a read this cycle (from the `is_mem` stage, predicate-gated)
- `mmu_write_en`  in  NUM_LANES  lane issues a write (predicate-gated by the lane)
- `mmu_write_force`  in  NUM_LANES  write has priority within its bank
- `mmu_write_data`  in  NUM_LANES*9  per-lane write word, lane i at `[9i+8:9i]`
- `mmu_addr`  in  NUM_LANES*18  per-lane word address, lane i at `[18i+17:18i]`
- `mmu_read_data`  out  NUM_LANES*9  per-lane read word, registered
- `stall`  out  1  combinational; request set not complete, lanes hold inputs

## Operation
- Lane i is *pending* when `(lane_rd_en[i] | mmu_write_en[i]) & ~served[i]`.
  - `served` is a NUM_LANES-bit mask register.
- Per-bank grant each cycle, among pending lanes mapped to that bank, in this order:
  - first, the lowest-indexed lane with `mmu_write_en & mmu_write_force`;
  - otherwise, the lowest-indexed pending lane.
  - At most one grant per bank per cycle.
- Granted write: `bank[row] <= data` at the clock edge.
- Granted read: `read_q[i] <= bank[row]`, with read-before-write semantics within a cycle.
  - Same-cycle writes by other lanes to the same word are impossible, since there is one grant per bank.
- A lane with both `lane_rd_en` and `mmu_write_en` set performs the write and returns the old word.
- `stall = |(pending & ~grant)`.
- State machine, two states:
  - **IDLE** (`served == 0`):
    - if `stall`, then `served <= grant` and go to **BUSY**;
    - else `served` stays 0.
  - **BUSY**:
    - `served <= served | grant`;
    - when `stall` is 0 this cycle, `served <= 0` and go to **IDLE**.
- Lanes hold `addr`, `data`, and enables stable while `stall` is 1. The block does not re-check this.
- `read_q[i]` holds its value until lane i's next read grant.
- Lanes not reading keep their previous `mmu_read_data`.
- Out-of-range upper address bits are ignored (aliasing); no error is signalled.

## Timing
- A grant in cycle t makes read data valid on `mmu_read_data` from t+1 onward.
  - This matches the lane's next-stage sampling.
- A write in cycle t is visible to reads granted in cycle t+1 or later.
- k lanes on one bank take k cycles: `stall` is high for cycles 0..k-2 and low in cycle k-1.
- Completion latency = maximum per-bank pending count.
- Reset values: `served = 0`, state IDLE, all `read_q = 0`, `stall = 0` while `rst` is high.
  - Bank contents are not cleared.
- Reset mid-BUSY: no grants and no writes in the reset cycle; `served` is cleared; the request set is abandoned.
- When `rst` is high, `stall` is forced to 0 and grants are suppressed.
- A new request set may arrive in the cycle immediately after `stall` drops, giving back-to-back sets.

## Test plan
- Lanes 0–3 read addrs 0,1,2,3 (distinct banks) holding 9'h011..9'h014 -> `stall` stays 0; all four `mmu_read_data` show 011..014 at t+1.
- Lanes 0–3 write 9'h0A0..9'h0A3 to addrs 4,8,12,16 (all bank 0) -> `stall` high 3 cycles; then reads of those addrs return A0..A3.
- Lanes 0 and 2 write addr 8 (bank 0), lane 2 forced, data 1FF vs 055 -> lane 2 granted first; final word is 055; `stall` is high 1 cycle.
- Lane 0 writes 0x33 to addr 20; lane 1 reads addr 20 in the same set -> lane 1 granted the cycle after, reads 0x33.
- Three lanes conflict on bank 1 and `rst` is pulsed during the second stall cycle -> `stall` is 0 with `rst`; the unserved lane's write is absent; the served lane's write persists; `read_q` is 0.
- A lane with both rd and wr enabled to addr 5 (old 0x07, new 0x09) -> returns 0x07; a subsequent read returns 0x09.

Source files
------------

// File: rtl/mmu_bank_if.sv
// Lane-side MMU request/response bundle for mmu_bank_server.
//   master : SIMD lanes (drive requests, receive read data and stall)
//   slave  : bank server (receives requests, drives read data and stall)
// Per-lane fields are packed: lane i write/read word at [9i+8:9i],
// lane i word address at [18i+17:18i].
interface mmu_bank_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0]    lane_rd_en;
    logic [NUM_LANES-1:0]    mmu_write_en;
    logic [NUM_LANES-1:0]    mmu_write_force;
    logic [NUM_LANES*9-1:0]  mmu_write_data;
    logic [NUM_LANES*18-1:0] mmu_addr;
    logic [NUM_LANES*9-1:0]  mmu_read_data;
    logic                    stall;

    modport master (
        output lane_rd_en, mmu_write_en, mmu_write_force, mmu_write_data, mmu_addr,
        input  mmu_read_data, stall
    );

    modport slave (
        input  lane_rd_en, mmu_write_en, mmu_write_force, mmu_write_data, mmu_addr,
        output mmu_read_data, stall
    );
endinterface

// File: rtl/mmu_bank_server.sv
// Banked word store serving one read/write request per SIMD lane per
// instruction. Lanes on distinct banks are served in the same cycle; bank
// conflicts are serialised by holding stall high until every lane of the
// request set has been granted.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : mmu_bank_if.slave (lane enables, force, write data, address in;
//          registered per-lane read data and combinational stall out)
//
// FSM states:
//   state  | meaning
//   S_IDLE | no lanes served yet in the current request set (served == 0)
//   S_BUSY | part of a conflicting set served; served holds granted lanes
module mmu_bank_server #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 4096
) (
    input logic       clk,
    input logic       rst,
    mmu_bank_if.slave bus
);
    localparam int DATA_W = 9;
    localparam int ADDR_W = 18;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(BANK_DEPTH);
    localparam int HIGH_W = ADDR_W - BANK_W - ROW_W;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_LANES-1:0]        served_q, served_d;
    logic [NUM_LANES*DATA_W-1:0] read_q, read_d;

    logic [DATA_W-1:0] bank_mem [NUM_BANKS][BANK_DEPTH];

    logic [BANK_W-1:0]    lane_bank [NUM_LANES];
    logic [ROW_W-1:0]     lane_row  [NUM_LANES];
    logic [NUM_LANES-1:0] addr_high_unused;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] grant;
    logic [NUM_LANES-1:0] force_sel;
    logic [NUM_LANES-1:0] first_sel;
    logic                 force_found;
    logic                 first_found;
    logic                 stall_c;

    // Upper address bits alias onto the same word; they are deliberately dropped.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_bank[i]        = bus.mmu_addr[ADDR_W*i +: BANK_W];
            lane_row[i]         = bus.mmu_addr[ADDR_W*i + BANK_W +: ROW_W];
            addr_high_unused[i] = ^bus.mmu_addr[ADDR_W*i + BANK_W + ROW_W +: HIGH_W];
        end
    end

    assign pending = (bus.lane_rd_en | bus.mmu_write_en) & ~served_q;

    // One grant per bank: lowest forced writer wins, else lowest pending lane.
    always_comb begin
        grant       = '0;
        force_sel   = '0;
        first_sel   = '0;
        force_found = 1'b0;
        first_found = 1'b0;
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                force_sel   = '0;
                first_sel   = '0;
                force_found = 1'b0;
                first_found = 1'b0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (pending[i] && (lane_bank[i] == BANK_W'(b))) begin
                        if (!first_found) begin
                            first_sel[i] = 1'b1;
                            first_found  = 1'b1;
                        end
                        if (bus.mmu_write_en[i] && bus.mmu_write_force[i] && !force_found) begin
                            force_sel[i] = 1'b1;
                            force_found  = 1'b1;
                        end
                    end
                end
                grant = grant | (force_found ? force_sel : first_sel);
            end
        end
    end

    assign stall_c   = !rst && (|(pending & ~grant));
    assign bus.stall = stall_c;

    // Read sees the word before this cycle's write (read-before-write); a lane
    // that both reads and writes therefore returns the old word.
    always_comb begin
        read_d = read_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i] && bus.lane_rd_en[i]) begin
                read_d[DATA_W*i +: DATA_W] = bank_mem[lane_bank[i]][lane_row[i]];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        case (state_q)
            S_IDLE: begin
                if (stall_c) begin
                    served_d = grant;
                    state_d  = S_BUSY;
                end else begin
                    served_d = '0;
                end
            end
            S_BUSY: begin
                if (stall_c) begin
                    served_d = served_q | grant;
                end else begin
                    served_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                served_d = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            served_q <= '0;
            read_q   <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            read_q   <= read_d;
        end
    end

    // Bank contents survive reset; grant is already forced low during rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i] && bus.mmu_write_en[i]) begin
                bank_mem[lane_bank[i]][lane_row[i]] <= bus.mmu_write_data[DATA_W*i +: DATA_W];
            end
        end
    end

    assign bus.mmu_read_data = read_q;

endmodule

// File: tb/tb_mmu_bank_server.sv
module tb_mmu_bank_server;
    localparam int NL    = 4;
    localparam int WORDS = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mmu_bank_if #(.NUM_LANES(NL)) bus ();

    mmu_bank_server #(
        .NUM_LANES (NL),
        .NUM_BANKS (4),
        .BANK_DEPTH(4096)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stalls;
        logic [35:0] rd_vec;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [8:0]  ref_mem [WORDS];
    logic [35:0] ref_rd = '0;
    bit          sb_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts stall cycles of the current set and, on completion,
    // compares against the scoreboard and checks read data one cycle later.
    int          mon_stalls = 0;
    bit          chk_pend = 1'b0;
    logic [35:0] chk_vec;
    always @(negedge clk) begin
        if (chk_pend) begin
            check("read_data", 64'(bus.mmu_read_data), 64'(chk_vec));
            chk_pend = 1'b0;
        end
        if (sb_en && !rst && (|(bus.lane_rd_en | bus.mmu_write_en))) begin
            if (bus.stall) begin
                mon_stalls++;
            end else if (exp_q.size() == 0) begin
                check("unexpected_set", 64'(mon_stalls), 64'hFFFF);
                mon_stalls = 0;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("stall_cycles", 64'(mon_stalls), 64'(e.stalls));
                chk_vec    = e.rd_vec;
                chk_pend   = 1'b1;
                mon_stalls = 0;
            end
        end
    end

    task automatic drive_idle();
        bus.lane_rd_en      = '0;
        bus.mmu_write_en    = '0;
        bus.mmu_write_force = '0;
        bus.mmu_write_data  = '0;
        bus.mmu_addr        = '0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: per bank, forced writers in lane order, then the rest in lane
    // order; one per cycle, each read seeing everything written before it.
    task automatic model_set(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] frc,
                             input logic [35:0] wdata, input logic [71:0] addr, output int stalls);
        int maxlen = 0;
        for (int b = 0; b < 4; b++) begin
            int len = 0;
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < NL; i++) begin
                    int  a;
                    bit  forced;
                    a      = int'(addr[18*i +: 18]) % WORDS;
                    forced = wr[i] && frc[i];
                    if ((rd[i] || wr[i]) && (a % 4 == b) && (forced == (pass == 0))) begin
                        len++;
                        if (rd[i]) ref_rd[9*i +: 9] = ref_mem[a];
                        if (wr[i]) ref_mem[a] = wdata[9*i +: 9];
                    end
                end
            end
            if (len > maxlen) maxlen = len;
        end
        stalls = maxlen - 1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the set completes.
    task automatic run_set(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] frc,
                           input logic [35:0] wdata, input logic [71:0] addr);
        exp_t e;
        bit   done = 1'b0;
        model_set(rd, wr, frc, wdata, addr, e.stalls);
        e.rd_vec = ref_rd;
        exp_q.push_back(e);
        bus.lane_rd_en      = rd;
        bus.mmu_write_en    = wr;
        bus.mmu_write_force = frc;
        bus.mmu_write_data  = wdata;
        bus.mmu_addr        = addr;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (!bus.stall) done = 1'b1;
        end
        if (!done) check("set_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    function automatic logic [71:0] pack_addr(input int a0, input int a1, input int a2, input int a3);
        logic [71:0] v;
        v = {18'(a3), 18'(a2), 18'(a1), 18'(a0)};
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset with a conflicting request present: stall must stay 0.
        drive_idle();
        rst = 1'b1;
        bus.lane_rd_en = 4'b0011;
        bus.mmu_addr   = pack_addr(0, 4, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("reset_stall", 64'(bus.stall), 64'd0);
            check("reset_read_q", 64'(bus.mmu_read_data), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        sb_en = 1'b1;

        // Initialise addresses 0..63 (four distinct banks per set).
        for (int k = 0; k < 16; k++) begin
            run_set(4'b0000, 4'b1111, 4'b0000, 36'($urandom) ^ {$urandom} << 4,
                    pack_addr(4*k, 4*k+1, 4*k+2, 4*k+3));
        end

        // Distinct banks: reads served together, no stall.
        run_set(4'b0000, 4'b1111, 4'b0000, {9'h014, 9'h013, 9'h012, 9'h011}, pack_addr(0, 1, 2, 3));
        run_set(4'b1111, 4'b0000, 4'b0000, '0, pack_addr(0, 1, 2, 3));
        // All four lanes on bank 0: stall for 3 cycles, then read back.
        run_set(4'b0000, 4'b1111, 4'b0000, {9'h0A3, 9'h0A2, 9'h0A1, 9'h0A0}, pack_addr(4, 8, 12, 16));
        run_set(4'b1111, 4'b0000, 4'b0000, '0, pack_addr(4, 8, 12, 16));
        // Forced lane 2 beats lane 0 on addr 8; lane 0 writes last.
        run_set(4'b0000, 4'b0101, 4'b0100, {9'h000, 9'h1FF, 9'h000, 9'h055}, pack_addr(8, 0, 8, 0));
        run_set(4'b0001, 4'b0000, 4'b0000, '0, pack_addr(8, 0, 0, 0));
        // Write then same-set read of addr 20.
        run_set(4'b0010, 4'b0001, 4'b0000, {9'h000, 9'h000, 9'h000, 9'h033}, pack_addr(20, 20, 0, 0));

        // Reset during the second stall cycle of a bank-1 conflict.
        idle(2);
        sb_en = 1'b0;
        bus.mmu_write_en   = 4'b0111;
        bus.mmu_write_data = {9'h000, 9'h103, 9'h102, 9'h101};
        bus.mmu_addr       = pack_addr(1, 5, 9, 0);
        @(negedge clk);
        check("rst_pre_stall", 64'(bus.stall), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        check("rst_mid_read_q", 64'(bus.mmu_read_data), 64'd0);
        ref_mem[1] = 9'h101;
        ref_rd     = '0;
        @(posedge clk);
        #1;
        sb_en = 1'b1;
        run_set(4'b0111, 4'b0000, 4'b0000, '0, pack_addr(1, 5, 9, 0));

        // Read+write on one lane returns the old word.
        run_set(4'b0000, 4'b0001, 4'b0000, 36'h007, pack_addr(5, 0, 0, 0));
        run_set(4'b0001, 4'b0001, 4'b0000, 36'h009, pack_addr(5, 0, 0, 0));
        run_set(4'b0001, 4'b0000, 4'b0000, '0, pack_addr(5, 0, 0, 0));

        // Randomised sets, with aliased upper address bits and back-to-back runs.
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  rd, wr, frc;
            logic [35:0] wd;
            logic [71:0] ad;
            rd  = 4'($urandom);
            wr  = 4'($urandom);
            frc = 4'($urandom);
            if ((rd | wr) == 4'b0000) rd = 4'b0001;
            wd = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
            for (int i = 0; i < NL; i++) begin
                ad[18*i +: 18] = 18'($urandom_range(0, 63)) | (18'($urandom_range(0, 15)) << 14);
            end
            run_set(rd, wr, frc, wd, ad);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end

        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
